// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter among NREQ requesters.
// Latency: req seen in IDLE -> start pulse next cycle; conversion complete -> done next cycle.
// Backpressure: requests are level-held; only one conversion is in flight, and other requesters wait in IDLE arbitration.
// Optional WAIT timeout is enabled by defining A2D_ARB_TIMEOUT_EN (default build: no timeout, err_timeout tied low).
module a2d_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_chnnl,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [11:0]       rd_data,
    output logic              busy,
    output logic [2:0]        a2d_chnnl,
    output logic              a2d_strt_cnv,
    input  logic              a2d_cnv_cmplt,
    input  logic [11:0]       a2d_res,
    output logic              err_timeout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reject parameter values that make the arbiter or timeout meaningless.
    if (NREQ < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("a2d_arbiter: NREQ and TIMEOUT_CYC must be at least 1");
    end

    state_t          state;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   last_served;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [2:0]      pick_chn;

`ifdef A2D_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;
    assign err_timeout = tmo_flag;
`else
    assign err_timeout = 1'b0;
`endif

    // Round-robin pick: the requester with the smallest distance past last_served wins.
    always_comb begin
        int d;
        int best;
        d        = 0;
        best     = NREQ;
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        pick_chn = 3'b000;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(last_served) - 1;
            if (d < 0) begin
                d = d + NREQ;
            end
            if (req[i] && (d < best)) begin
                best     = d;
                pick_vld = 1'b1;
                pick_idx = IW'(i);
                pick_oh  = '0;
                pick_oh[i] = 1'b1;
                pick_chn = req_chnnl[3*i +: 3];
            end
        end
    end

    // Controller FSM with all outputs registered; the channel and winner are frozen at grant time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            win_idx      <= '0;
            last_served  <= IW'(NREQ - 1);
            gnt          <= '0;
            done         <= '0;
            rd_data      <= 12'h000;
            busy         <= 1'b0;
            a2d_chnnl    <= 3'b000;
            a2d_strt_cnv <= 1'b0;
`ifdef A2D_ARB_TIMEOUT_EN
            tmo_cnt      <= '0;
            tmo_flag     <= 1'b0;
`endif
        end else begin
            a2d_strt_cnv <= 1'b0;
            done         <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state        <= START;
                        win_idx      <= pick_idx;
                        gnt          <= pick_oh;
                        a2d_chnnl    <= pick_chn;
                        a2d_strt_cnv <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef A2D_ARB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (a2d_cnv_cmplt) begin
                        rd_data <= a2d_res;
                        done    <= gnt;
                        state   <= DONE;
`ifdef A2D_ARB_TIMEOUT_EN
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        // Converter never answered: report an all-ones result and latch the error.
                        rd_data  <= 12'hFFF;
                        done     <= gnt;
                        state    <= DONE;
                        tmo_flag <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    gnt         <= '0;
                    busy        <= 1'b0;
                    last_served <= win_idx;
`ifdef A2D_ARB_TIMEOUT_EN
                    tmo_cnt     <= '0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
module tb_a2d_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  req_chnnl;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [11:0] rd_data;
    logic        busy;
    logic [2:0]  a2d_chnnl;
    logic        a2d_strt_cnv;
    logic        a2d_cnv_cmplt;
    logic [11:0] a2d_res;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;
    int model_last;

    a2d_arbiter #(.NREQ(3), .TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .req_chnnl     (req_chnnl),
        .gnt           (gnt),
        .done          (done),
        .rd_data       (rd_data),
        .busy          (busy),
        .a2d_chnnl     (a2d_chnnl),
        .a2d_strt_cnv  (a2d_strt_cnv),
        .a2d_cnv_cmplt (a2d_cnv_cmplt),
        .a2d_res       (a2d_res),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  r;
        logic [8:0]  ch;
        int          dly;
        logic [11:0] res;
        int          w;
        logic [2:0]  chn;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Round-robin reference: first requester found scanning upward from last+1, wrapping.
    function automatic int rr_pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (((r >> c) & 3'b001) != 3'b000) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] chn_of(input logic [8:0] ch, input int w);
        return 3'(ch >> (3 * w));
    endfunction

    function automatic logic [2:0] onehot(input int w);
        logic [2:0] v;
        v = 3'b001;
        return v << w;
    endfunction

    // One full service starting at a negedge with the DUT idle.
    task automatic serve(input logic [2:0] r, input logic [8:0] ch, input int dly,
                         input logic [11:0] res, input int w, input logic [2:0] echn);
        req       = r;
        req_chnnl = ch;
        @(negedge clk);
        chk("strt_pulse", 32'(a2d_strt_cnv), 32'd1);
        chk("gnt_start", 32'(gnt), 32'(onehot(w)));
        chk("chnnl_start", 32'(a2d_chnnl), 32'(echn));
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
        end
        chk("strt_low_wait", 32'(a2d_strt_cnv), 32'd0);
        chk("done_low_wait", 32'(done), 32'd0);
        a2d_res       = res;
        a2d_cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d_cnv_cmplt = 1'b0;
        chk("done_pulse", 32'(done), 32'(onehot(w)));
        chk("rd_data", 32'(rd_data), 32'(res));
        chk("gnt_done", 32'(gnt), 32'(onehot(w)));
        chk("chnnl_done", 32'(a2d_chnnl), 32'(echn));
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("gnt_clear", 32'(gnt), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd"}, 32'(rd_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_chnnl"}, 32'(a2d_chnnl), 32'd0);
        chk({tag, "_strt"}, 32'(a2d_strt_cnv), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic do_reset();
        req           = 3'b000;
        a2d_cnv_cmplt = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        model_last    = 2;
    endtask

    initial begin
        vec_t vt[9];
        logic [11:0] last_rd;
        int seen;
        int done_at;

        req           = 3'b000;
        req_chnnl     = 9'd0;
        a2d_cnv_cmplt = 1'b0;
        a2d_res       = 12'h000;
        rst_n         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n      = 1'b1;
        model_last = 2;
        @(negedge clk);

        // Contention from reset (0,1,2,0), then single requests and mixed patterns.
        vt[0] = '{3'b111, 9'b011_010_001, 3,  12'h111, 0, 3'd1};
        vt[1] = '{3'b111, 9'b011_010_001, 5,  12'h222, 1, 3'd2};
        vt[2] = '{3'b111, 9'b011_010_001, 2,  12'h333, 2, 3'd3};
        vt[3] = '{3'b111, 9'b011_010_001, 1,  12'h444, 0, 3'd1};
        vt[4] = '{3'b010, 9'b000_100_000, 20, 12'hA5C, 1, 3'd4};
        vt[5] = '{3'b101, 9'b101_000_110, 4,  12'h0F0, 2, 3'd5};
        vt[6] = '{3'b101, 9'b101_000_110, 2,  12'h00F, 0, 3'd6};
        vt[7] = '{3'b110, 9'b000_111_000, 6,  12'hFFE, 1, 3'd7};
        vt[8] = '{3'b011, 9'b000_001_000, 1,  12'h800, 0, 3'd0};
        for (int i = 0; i < 9; i++) begin
            serve(vt[i].r, vt[i].ch, vt[i].dly, vt[i].res, vt[i].w, vt[i].chn);
        end
        last_rd = 12'h800;

        // Stray completes in IDLE and in START are ignored.
        req           = 3'b000;
        a2d_res       = 12'h123;
        a2d_cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d_cnv_cmplt = 1'b0;
        chk("stray_idle_done", 32'(done), 32'd0);
        chk("stray_idle_rd", 32'(rd_data), 32'(last_rd));
        chk("stray_idle_busy", 32'(busy), 32'd0);
        req       = 3'b001;
        req_chnnl = 9'b000_000_101;
        @(negedge clk);
        chk("stray_strt", 32'(a2d_strt_cnv), 32'd1);
        a2d_res       = 12'h777;
        a2d_cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d_cnv_cmplt = 1'b0;
        chk("stray_start_done", 32'(done), 32'd0);
        chk("stray_start_rd", 32'(rd_data), 32'(last_rd));
        chk("stray_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        a2d_res       = 12'h3C3;
        a2d_cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d_cnv_cmplt = 1'b0;
        chk("stray_real_done", 32'(done), 32'b001);
        chk("stray_real_rd", 32'(rd_data), 32'h3C3);
        req = 3'b000;
        @(negedge clk);

        // Channel change and request drop mid-service do not disturb the conversion.
        req       = 3'b100;
        req_chnnl = 9'b011_000_000;
        @(negedge clk);
        chk("mid_chnnl_start", 32'(a2d_chnnl), 32'd3);
        @(negedge clk);
        req_chnnl = 9'b111_000_000;
        req       = 3'b000;
        @(negedge clk);
        @(negedge clk);
        chk("mid_chnnl_wait", 32'(a2d_chnnl), 32'd3);
        chk("mid_gnt_wait", 32'(gnt), 32'b100);
        a2d_res       = 12'h456;
        a2d_cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d_cnv_cmplt = 1'b0;
        chk("mid_done", 32'(done), 32'b100);
        chk("mid_chnnl_done", 32'(a2d_chnnl), 32'd3);
        chk("mid_rd", 32'(rd_data), 32'h456);
        @(negedge clk);
        chk("mid_idle", 32'(busy), 32'd0);

        // Reset while waiting abandons the conversion.
        req       = 3'b010;
        req_chnnl = 9'b000_110_000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rstw_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req   = 3'b000;
        #1;
        check_reset_vals("rst_wait");
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = 2;
        @(negedge clk);
        a2d_res       = 12'h999;
        a2d_cnv_cmplt = 1'b1;
        @(negedge clk);
        a2d_cnv_cmplt = 1'b0;
        chk("rstw_no_done", 32'(done), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_rd", 32'(rd_data), 32'd0);
        @(negedge clk);
        chk("rstw_no_done2", 32'(done), 32'd0);

        // Converter that never completes.
        req       = 3'b001;
        req_chnnl = 9'b000_000_010;
        @(negedge clk);
        chk("tmo_strt", 32'(a2d_strt_cnv), 32'd1);
        done_at = 0;
        seen    = 0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            @(negedge clk);
            if (done != 3'b000) begin
                done_at = i;
                req     = 3'b000;
            end
            if (busy == 1'b1) seen++;
        end
`ifdef A2D_ARB_TIMEOUT_EN
        chk("tmo_done_cycle", 32'(done_at), 32'd17);
        chk("tmo_rd", 32'(rd_data), 32'hFFF);
        chk("tmo_err", 32'(err_timeout), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("tmo_err_sticky", 32'(err_timeout), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
`else
        chk("notmo_no_done", 32'(done_at), 32'd0);
        chk("notmo_busy", 32'(seen), 32'd40);
        chk("notmo_err", 32'(err_timeout), 32'd0);
`endif
        do_reset();
        chk("post_tmo_err", 32'(err_timeout), 32'd0);
        chk("post_tmo_busy", 32'(busy), 32'd0);

        // Randomized services against the round-robin model.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  r;
            logic [8:0]  ch;
            logic [11:0] res;
            int          w;
            r   = 3'($urandom_range(1, 7));
            ch  = 9'($urandom);
            res = 12'($urandom);
            w   = rr_pick(r, model_last);
            serve(r, ch, int'($urandom_range(1, 6)), res, w, chn_of(ch, w));
            model_last = w;
            if ($urandom_range(0, 3) == 0) begin
                req = 3'b000;
                @(negedge clk);
                chk("rand_gap_busy", 32'(busy), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a2d_arbiter.md
A2D_ARBITER -- requirements
Module: a2d_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the single A2D converter.
REQ-002 Parameter TIMEOUT_CYC, default 4096: WAIT-state cycle limit, used only when A2D_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester conversion request, level; held high until the matching done.
REQ-006 req_chnnl  input  3*NREQ  requested A2D channel; bits [3i+2:3i] belong to requester i.
REQ-007 gnt  output  NREQ  one-hot grant, high from grant through the done cycle inclusive.
REQ-008 done  output  NREQ  one-cycle pulse to the served requester when rd_data is valid.
REQ-009 rd_data  output  12  conversion result; valid in the done cycle; held until the next capture.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 a2d_chnnl  output  3  channel to the A2D interface.
REQ-012 a2d_strt_cnv  output  1  one-cycle conversion start pulse to the A2D interface.
REQ-013 a2d_cnv_cmplt  input  1  conversion-complete pulse from the A2D interface.
REQ-014 a2d_res  input  12  result from the A2D interface; sampled only on a2d_cnv_cmplt in WAIT.
REQ-015 err_timeout  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, DONE, encoded in 2 bits.
REQ-017 IDLE: when any req bit is high, latch winner index and its req_chnnl, set gnt, go to START next cycle; otherwise stay.
REQ-018 Arbitration SHALL be round-robin: search begins at (last_served+1) mod NREQ; last_served resets to NREQ-1, so requester 0 wins first.
REQ-019 START: a2d_strt_cnv high exactly this one cycle; go to WAIT.
REQ-020 WAIT: on a2d_cnv_cmplt, capture a2d_res into rd_data and go to DONE; otherwise stay.
REQ-021 DONE: done[winner] high one cycle, last_served updated to winner, go to IDLE; gnt clears on leaving DONE.
REQ-022 Latency: req seen in IDLE at cycle N -> a2d_strt_cnv at N+1; a2d_cnv_cmplt at cycle M -> done at M+1.
REQ-023 a2d_chnnl SHALL be registered and stable from START through DONE; req_chnnl changes after grant are ignored.
REQ-024 a2d_cnv_cmplt outside WAIT SHALL be ignored.
REQ-025 req deasserted mid-service does not abort; the conversion completes and done still pulses.
REQ-026 Simultaneous requests: exactly one grant per service; the same requester cannot win twice in a row while another requests.
REQ-027 A requester whose req is still high in the done cycle is eligible again in the next IDLE under round-robin order.

Reset
REQ-028 Asynchronous rst_n low SHALL force IDLE, gnt=0, done=0, rd_data=12'h000, busy=0, a2d_chnnl=3'b000, a2d_strt_cnv=0, err_timeout=0, last_served=NREQ-1, timeout counter=0.
REQ-029 Reset mid-conversion SHALL abandon the conversion; a later a2d_cnv_cmplt is ignored per REQ-024.

Configuration
REQ-030 With A2D_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT; after TIMEOUT_CYC cycles without a2d_cnv_cmplt, go to DONE with rd_data=12'hFFF and set err_timeout until reset.
REQ-031 Without A2D_ARB_TIMEOUT_EN: WAIT has no limit, no counter is built, err_timeout is tied 0.

Verification
REQ-032 Single request: req=3'b010, chnnl1=3'd4, cmplt 20 cycles after start with res=12'hA5C -> strt_cnv one cycle after req, a2d_chnnl=4, done[1] next cycle, rd_data=12'hA5C.
REQ-033 Contention: req=3'b111 held for 4 services -> grant order 0,1,2,0; one strt_cnv per service.
REQ-034 Stray complete: cnv_cmplt pulsed in IDLE and in START -> no done, rd_data unchanged.
REQ-035 Mid-service change: req_chnnl of the winner changed 3->7 during WAIT -> a2d_chnnl stays 3.
REQ-036 Reset in WAIT, then cnv_cmplt -> all outputs at reset values, no done.
REQ-037 With macro, TIMEOUT_CYC=16, no cnv_cmplt -> done after 16 WAIT cycles, rd_data=12'hFFF, err_timeout=1 until rst_n; without macro -> busy stays high.
